axis_buf: RTL and testbench

Parametrised AXI4-Stream buffer: the next generation of the single-register AXI data path. It accepts beats on a slave stream port, stores up to DEPTH beats in order, and presents them on a master stream port with full valid/ready handshaking and back-pressure. It sits between any AXI-Stream producer and consumer in the AXI4 subsystem as an elastic decoupling stage.

---
 rtl/axis_buf_pkg.sv | 23 ++
 rtl/axis_buf_if.sv | 21 ++
 rtl/axis_buf_ctrl.sv | 73 +++++++
 rtl/axis_buf.sv | 76 +++++++
 tb/tb_axis_buf.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/axis_buf_pkg.sv
// axis_buf_pkg: shared constants, pointer-width helper and entry layout for axis_buf.
// The optional TLAST path is enabled by defining AXIS_BUF_TLAST_EN.
package axis_buf_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultDepth     = 4;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned ptr_width(input int unsigned n);
    int unsigned w = 0;
    while ((64'd1 << w) < 64'(n)) begin
      w++;
    end
    return w;
  endfunction

  // Storage entry when TLAST travels with its beat: {tlast, tdata}.
  typedef struct packed {
    logic                        tlast;
    logic [DefaultDataWidth-1:0] tdata;
  } entry_t;

endpackage

// File: rtl/axis_buf_if.sv
// axis_buf_if: one AXI4-Stream link. TLAST exists only when AXIS_BUF_TLAST_EN is defined.
interface axis_buf_if
  import axis_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
`ifdef AXIS_BUF_TLAST_EN
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
`endif

endinterface

// File: rtl/axis_buf_ctrl.sv
// axis_buf_ctrl: read/write pointers, occupancy counter and handshake generation.
// tready is registered from the next-state level so it never follows the consumer's
// ready combinationally.
module axis_buf_ctrl
  import axis_buf_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  localparam int unsigned PtrW = ptr_width(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            s_tvalid_i,
  input  logic            m_tready_i,
  output logic            s_tready_o,
  output logic            m_tvalid_o,
  output logic            push_o,
  output logic [PtrW-1:0] wr_ptr_o,
  output logic [PtrW-1:0] rd_ptr_o,
  output logic [PtrW:0]   level_o
);

  localparam logic [PtrW:0]   LevelFull = (PtrW + 1)'(DEPTH);
  localparam logic [PtrW:0]   LevelOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   level_q, level_d;
  logic            s_tready_q, s_tready_d;
  logic            m_tvalid;
  logic            push, pop;

  // Handshake decode and next-state for pointers, level and registered tready.
  always_comb begin
    m_tvalid   = (level_q != '0);
    push       = s_tvalid_i & s_tready_q;
    pop        = m_tvalid & m_tready_i;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
    s_tready_d = (level_d < LevelFull);
  end

  // State registers; tready stays low throughout reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      s_tready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      s_tready_q <= s_tready_d;
    end
  end

  assign s_tready_o = s_tready_q;
  assign m_tvalid_o = m_tvalid;
  assign push_o     = push;
  assign wr_ptr_o   = wr_ptr_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign level_o    = level_q;

endmodule

// File: rtl/axis_buf.sv
// axis_buf: DEPTH-entry elastic AXI4-Stream FIFO. Holds the storage array and head mux;
// pointer/level control lives in axis_buf_ctrl. Define AXIS_BUF_TLAST_EN to carry TLAST.
module axis_buf
  import axis_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = DefaultDepth
) (
  input  logic                     ACLK,
  input  logic                     ARST,
  axis_buf_if.slave                s_axis,
  axis_buf_if.master               m_axis,
  output logic [ptr_width(DEPTH):0] LEVEL
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
`ifdef AXIS_BUF_TLAST_EN
  localparam int unsigned EntryW = DATA_WIDTH + 1;
`else
  localparam int unsigned EntryW = DATA_WIDTH;
`endif

  logic [EntryW-1:0] mem_q [DEPTH];
  logic [EntryW-1:0] entry_in;
  logic [EntryW-1:0] head;
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic              push;
  logic              s_tready;
  logic              m_tvalid;

  axis_buf_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk_i      (ACLK),
    .rst_i      (ARST),
    .s_tvalid_i (s_axis.tvalid),
    .m_tready_i (m_axis.tready),
    .s_tready_o (s_tready),
    .m_tvalid_o (m_tvalid),
    .push_o     (push),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .level_o    (LEVEL)
  );

`ifdef AXIS_BUF_TLAST_EN
  assign entry_in = {s_axis.tlast, s_axis.tdata};
`else
  assign entry_in = s_axis.tdata;
`endif

  // Storage array; cleared on reset so discarded beats can never reappear on the head.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= entry_in;
    end
  end

  // Head-of-queue mux; stable until popped because rd_ptr only moves on a pop.
  always_comb begin
    head = mem_q[rd_ptr];
  end

  assign s_axis.tready = s_tready;
  assign m_axis.tvalid = m_tvalid;
  assign m_axis.tdata  = head[DATA_WIDTH-1:0];
`ifdef AXIS_BUF_TLAST_EN
  assign m_axis.tlast  = head[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_axis_buf.sv
// tb_axis_buf: directed self-checking bench for axis_buf (DATA_WIDTH=32, DEPTH=4).
module tb_axis_buf;

  logic       ACLK;
  logic       ARST;
  logic [2:0] LEVEL;

  int vectors     = 0;
  int miscompares = 0;

  axis_buf_if #(.DATA_WIDTH(32)) s_if ();
  axis_buf_if #(.DATA_WIDTH(32)) m_if ();

  axis_buf #(
    .DATA_WIDTH (32),
    .DEPTH      (4)
  ) dut (
    .ACLK   (ACLK),
    .ARST   (ARST),
    .s_axis (s_if.slave),
    .m_axis (m_if.master),
    .LEVEL  (LEVEL)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent;
    int rcvd;
    int model;
    int cyc;
    bit pushed;
    bit popped;

    ARST        = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b0;
`ifdef AXIS_BUF_TLAST_EN
    s_if.tlast  = 1'b0;
`endif

    // Reset held
    #3;
    chk("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_m_tdata", m_if.tdata, 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_s_tready", 32'(s_if.tready), 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
    ARST = 1'b0;
    chk("rel_s_tready_pre", 32'(s_if.tready), 32'd0);
    tick();
    chk("rel_s_tready_post", 32'(s_if.tready), 32'd1);

    // Single beat, held under back-pressure
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hDEADBEEF;
    tick();
    s_if.tvalid = 1'b0;
    chk("single_tvalid", 32'(m_if.tvalid), 32'd1);
    chk("single_tdata", m_if.tdata, 32'hDEADBEEF);
    chk("single_level", 32'(LEVEL), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("single_hold_tvalid", 32'(m_if.tvalid), 32'd1);
      chk("single_hold_tdata", m_if.tdata, 32'hDEADBEEF);
    end
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    chk("single_pop_level", 32'(LEVEL), 32'd0);
    chk("single_pop_tvalid", 32'(m_if.tvalid), 32'd0);

    // Fill to full, offer one more, free a slot
    s_if.tvalid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_if.tdata = 32'(i);
      tick();
    end
    chk("full_level", 32'(LEVEL), 32'd4);
    chk("full_s_tready", 32'(s_if.tready), 32'd0);
    chk("full_head", m_if.tdata, 32'd1);
    s_if.tdata = 32'd5;
    tick();
    chk("full_refuse_level", 32'(LEVEL), 32'd4);
    chk("full_refuse_head", m_if.tdata, 32'd1);
    m_if.tready = 1'b1;
    tick();
    m_if.tready = 1'b0;
    chk("full_pop_level", 32'(LEVEL), 32'd3);
    chk("full_pop_s_tready", 32'(s_if.tready), 32'd1);
    tick();
    s_if.tvalid = 1'b0;
    chk("full_accept5_level", 32'(LEVEL), 32'd4);
    m_if.tready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("full_order", m_if.tdata, 32'(i));
      tick();
    end
    m_if.tready = 1'b0;
    chk("full_drain_level", 32'(LEVEL), 32'd0);
    chk("full_drain_tvalid", 32'(m_if.tvalid), 32'd0);

    // Simultaneous push and pop at level 2
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hA1;
    tick();
    s_if.tdata  = 32'hA2;
    tick();
    chk("simul_pre_level", 32'(LEVEL), 32'd2);
    s_if.tdata  = 32'hA3;
    m_if.tready = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    chk("simul_level", 32'(LEVEL), 32'd2);
    chk("simul_head_a2", m_if.tdata, 32'hA2);
    tick();
    chk("simul_head_a3", m_if.tdata, 32'hA3);
    chk("simul_level1", 32'(LEVEL), 32'd1);
    tick();
    m_if.tready = 1'b0;
    chk("simul_empty", 32'(LEVEL), 32'd0);

    // Wrap-around with random valid/ready
    sent  = 0;
    rcvd  = 0;
    model = 0;
    cyc   = 0;
    while (rcvd < 20 && cyc < 2000) begin
      s_if.tvalid = (sent < 20) && ($urandom_range(0, 3) != 0);
      s_if.tdata  = 32'h0A + 32'(sent);
      m_if.tready = ($urandom_range(0, 2) != 0);
      pushed = s_if.tvalid && s_if.tready;
      popped = m_if.tvalid && m_if.tready;
      if (popped) chk("wrap_data", m_if.tdata, 32'h0A + 32'(rcvd));
      chk("wrap_level", 32'(LEVEL), 32'(model));
      tick();
      sent  += int'(pushed);
      rcvd  += int'(popped);
      model += int'(pushed) - int'(popped);
      cyc++;
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    chk("wrap_count", 32'(rcvd), 32'd20);
    chk("wrap_end_level", 32'(LEVEL), 32'd0);

`ifdef AXIS_BUF_TLAST_EN
    // TLAST travels with its beat
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'h12345678;
    s_if.tlast  = 1'b0;
    tick();
    s_if.tdata  = 32'h9ABCDEF0;
    s_if.tlast  = 1'b1;
    tick();
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    chk("tlast_first_data", m_if.tdata, 32'h12345678);
    chk("tlast_first_last", 32'(m_if.tlast), 32'd0);
    m_if.tready = 1'b1;
    tick();
    chk("tlast_second_data", m_if.tdata, 32'h9ABCDEF0);
    chk("tlast_second_last", 32'(m_if.tlast), 32'd1);
    tick();
    m_if.tready = 1'b0;
    chk("tlast_empty", 32'(LEVEL), 32'd0);
`endif

    // Reset mid-stream discards contents
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_if.tdata = 32'hC0 + 32'(i);
      tick();
    end
    s_if.tvalid = 1'b0;
    chk("mid_pre_level", 32'(LEVEL), 32'd3);
    #2;
    ARST = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("mid_rst_tdata", m_if.tdata, 32'd0);
    chk("mid_rst_level", 32'(LEVEL), 32'd0);
    chk("mid_rst_s_tready", 32'(s_if.tready), 32'd0);
    tick();
    ARST = 1'b0;
    chk("mid_rel_s_tready_pre", 32'(s_if.tready), 32'd0);
    m_if.tready = 1'b1;
    tick();
    chk("mid_rel_s_tready", 32'(s_if.tready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mid_no_ghost_tvalid", 32'(m_if.tvalid), 32'd0);
      tick();
    end
    chk("mid_no_ghost_level", 32'(LEVEL), 32'd0);
    m_if.tready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
